// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for the Goldschmidt divider datapath: steps the multiplier
// selects and the A/B/remainder enables through NITER refinement passes.
module fpdiv_ctrl #(
  parameter int NITER = 6
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       rm_in_i,
  output logic       rm_o,
  output logic [1:0] sel_mux3_o,
  output logic [1:0] sel_mux4_o,
  output logic       en_a_o,
  output logic       en_b_o,
  output logic       en_rem_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] iter_o
);

  if (NITER < 2 || NITER > 15) begin : g_niter_chk
    $error("fpdiv_ctrl: NITER must be in 2..15");
  end

  localparam logic [3:0] NITER_C = 4'(NITER);

  typedef enum logic [2:0] {
    S_IDLE, S_N1, S_D1, S_NK, S_DK, S_REM, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rm_q, rm_d;
  logic [1:0] sel3_q, sel3_d, sel4_q, sel4_d;
  logic       en_a_q, en_a_d, en_b_q, en_b_d, en_rem_q, en_rem_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [3:0] iter_q, iter_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rm_q     <= 1'b0;
      sel3_q   <= '0;
      sel4_q   <= '0;
      en_a_q   <= 1'b0;
      en_b_q   <= 1'b0;
      en_rem_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rm_q     <= rm_d;
      sel3_q   <= sel3_d;
      sel4_q   <= sel4_d;
      en_a_q   <= en_a_d;
      en_b_q   <= en_b_d;
      en_rem_q <= en_rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      iter_q   <= iter_d;
    end
  end

  // D1 and DK share the loop test: D1 runs with counter 1, so it only exits
  // straight to REM in the degenerate single-iteration case.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rm_d    = rm_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_N1;
        cnt_d   = 4'd1;
        rm_d    = rm_in_i;
      end
      S_N1: state_d = S_D1;
      S_D1, S_DK: begin
        if (cnt_q == NITER_C) begin
          state_d = S_REM;
        end else begin
          state_d = S_NK;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_NK:  state_d = S_DK;
      S_REM: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register in the same cycle.
  always_comb begin
    sel3_d   = 2'b00;
    sel4_d   = 2'b00;
    en_a_d   = 1'b0;
    en_b_d   = 1'b0;
    en_rem_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;
    iter_d   = '0;
    unique case (state_d)
      S_N1: begin
        en_a_d = 1'b1;
        iter_d = cnt_d;
      end
      S_D1: begin
        sel4_d = 2'b01;
        en_b_d = 1'b1;
        iter_d = cnt_d;
      end
      S_NK: begin
        sel3_d = 2'b01;
        sel4_d = 2'b10;
        en_a_d = 1'b1;
        iter_d = cnt_d;
      end
      S_DK: begin
        sel3_d = 2'b01;
        sel4_d = 2'b11;
        en_b_d = 1'b1;
        iter_d = cnt_d;
      end
      S_REM: begin
        sel3_d   = 2'b10;
        sel4_d   = 2'b10;
        en_rem_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign rm_o       = rm_q;
  assign sel_mux3_o = sel3_q;
  assign sel_mux4_o = sel4_q;
  assign en_a_o     = en_a_q;
  assign en_b_o     = en_b_q;
  assign en_rem_o   = en_rem_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign iter_o     = iter_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl: NITER=6 and NITER=2 instances share stimulus;
// each accepted start queues the expected per-cycle output vectors.
module tb_fpdiv_ctrl;
  typedef logic [13:0] vec_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, rm_in = 1'b0;

  logic       rm6, en_a6, en_b6, en_rem6, busy6, done6;
  logic [1:0] s3_6, s4_6;
  logic [3:0] iter6;
  logic       rm2, en_a2, en_b2, en_rem2, busy2, done2;
  logic [1:0] s3_2, s4_2;
  logic [3:0] iter2;

  fpdiv_ctrl #(.NITER(6)) u_dut6 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .rm_in_i(rm_in),
    .rm_o(rm6), .sel_mux3_o(s3_6), .sel_mux4_o(s4_6), .en_a_o(en_a6), .en_b_o(en_b6),
    .en_rem_o(en_rem6), .busy_o(busy6), .done_o(done6), .iter_o(iter6));

  fpdiv_ctrl #(.NITER(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .rm_in_i(rm_in),
    .rm_o(rm2), .sel_mux3_o(s3_2), .sel_mux4_o(s4_2), .en_a_o(en_a2), .en_b_o(en_b2),
    .en_rem_o(en_rem2), .busy_o(busy2), .done_o(done2), .iter_o(iter2));

  always #5 clk = ~clk;

  vec_t obs6, obs2;
  assign obs6 = {busy6, done6, en_a6, en_b6, en_rem6, s3_6, s4_6, iter6, rm6};
  assign obs2 = {busy2, done2, en_a2, en_b2, en_rem2, s3_2, s4_2, iter2, rm2};

  int   nchk = 0, nerr = 0;
  vec_t q6[$], q2[$];
  logic rmh6 = 1'b0, rmh2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  // st: 0 IDLE, 1 N1, 2 D1, 3 NK, 4 DK, 5 REM, 6 DONE
  function automatic vec_t ev(input int st, input int it, input logic r);
    logic       ea, eb, er;
    logic [1:0] s3, s4;
    logic [3:0] itv;
    ea  = (st == 1 || st == 3);
    eb  = (st == 2 || st == 4);
    er  = (st == 5);
    s3  = (st == 3 || st == 4) ? 2'b01 : (st == 5) ? 2'b10 : 2'b00;
    s4  = (st == 2) ? 2'b01 : (st == 3 || st == 5) ? 2'b10 : (st == 4) ? 2'b11 : 2'b00;
    itv = (st >= 1 && st <= 4) ? 4'(it) : 4'd0;
    return {st != 0, st == 6, ea, eb, er, s3, s4, itv, r};
  endfunction

  task automatic push_run(input int n, input logic r);
    vec_t v;
    for (int k = 1; k <= n + 1; k++) begin
      for (int h = 0; h < 2; h++) begin
        if (k > n) v = ev(5 + h, 0, r);
        else if (k == 1) v = ev(1 + h, 1, r);
        else v = ev(3 + h, k, r);
        if (n == 6) q6.push_back(v);
        else q2.push_back(v);
      end
    end
  endtask

  // Check the current cycle, then drive inputs for the next rising edge.
  task automatic cyc(input logic s, input logic a, input logic r);
    logic idle6, idle2;
    vec_t e6, e2;
    @(negedge clk);
    idle6 = (q6.size() == 0);
    idle2 = (q2.size() == 0);
    e6 = idle6 ? ev(0, 0, rmh6) : q6.pop_front();
    e2 = idle2 ? ev(0, 0, rmh2) : q2.pop_front();
    chk("seq6", obs6, e6);
    chk("seq2", obs2, e2);
    chk("excl6", ($countones({en_a6, en_b6, en_rem6}) <= 1), 1);
    chk("excl2", ($countones({en_a2, en_b2, en_rem2}) <= 1), 1);
    start = s;
    abort = a;
    rm_in = r;
    if (idle6 && s) begin push_run(6, r); rmh6 = r; end
    else if (!idle6 && a) q6.delete();
    if (idle2 && s) begin push_run(2, r); rmh2 = r; end
    else if (!idle2 && a) q2.delete();
  endtask

  initial begin
    @(negedge clk);
    chk("rst6", obs6, 0);
    chk("rst2", obs2, 0);
    reset = 1'b0;

    // single run, rm captured as 1
    cyc(1'b1, 1'b0, 1'b1);
    repeat (15) cyc(1'b0, 1'b0, 1'b0);

    // start re-pulsed mid-run must be ignored
    cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (12) cyc(1'b0, 1'b0, 1'b0);

    // abort in DK with iter 3, then a full fresh run
    cyc(1'b1, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (16) cyc(1'b0, 1'b0, 1'b0);

    // asynchronous reset between edges while in NK
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_arst_sel4", s4_6, 2'b10);
    chk("pre_arst_iter", iter6, 4'd2);
    reset = 1'b1;
    #1;
    chk("arst6", obs6, 0);
    chk("arst2", obs2, 0);
    chk("arst_busy", busy6, 0);
    q6.delete();
    q2.delete();
    rmh6 = 1'b0;
    rmh2 = 1'b0;
    @(negedge clk);
    chk("arst_hold6", obs6, 0);
    reset = 1'b0;

    // random start/abort traffic
    for (int i = 0; i < 1000; i++)
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 1'($urandom));
    repeat (20) cyc(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Sequencing controller for the Goldschmidt floating-point divider datapath (`fpdiv`). It replaces hand-driven bench stimulus with a Moore state machine. On a `start` request the controller issues the multiplier-input selects (`sel_mux3`, `sel_mux4`), the A/B/remainder register enables and the rounding mode for a fixed number of refinement iterations. It then signals `done` so a host or bench can sample the quotient.

## Interface
- `NITER`, default 6: number of Goldschmidt iterations (legal range 2..15); iteration 1 is the initial-approximation pass.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a division; accepted only in IDLE.
- `abort`  input  1  synchronous cancel; returns the machine to IDLE.
- `rm_in`  input  1  rounding mode, captured when `start` is accepted.
- `rm`  output  1  captured rounding mode, held until the next accepted start.
- `sel_mux3`  output  2  multiplier operand source: 00 = IA ROM, 01 = C register, 10 = remainder path.
- `sel_mux4`  output  2  multiplier other operand: 00 = numerator, 01 = denominator, 10 = A reg, 11 = B reg.
- `en_a`  output  1  load A (numerator product) register.
- `en_b`  output  1  load B (denominator product) register.
- `en_rem`  output  1  load remainder/final-rounding register.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  single-cycle completion pulse.
- `iter`  output  4  current iteration number, 1..NITER; 0 outside iteration states.

## Operation
- States: IDLE, N1, D1, NK, DK, REM, DONE.
- All outputs are registered Moore decodes of the state and counter.
- IDLE: all enables 0, selects 00, `busy` = 0, `iter` = 0. `start` = 1 -> N1; `rm` <= `rm_in`, counter <= 1.
- N1: `sel_mux4` = 00, `sel_mux3` = 00, `en_a` = 1. Next state D1.
- D1: `sel_mux4` = 01, `sel_mux3` = 00, `en_b` = 1. If NITER = 1 go to REM, else go to NK with counter <= 2. NITER = 1 is illegal; elaboration asserts NITER >= 2.
- NK: `sel_mux4` = 10, `sel_mux3` = 01, `en_a` = 1. Next state DK.
- DK: `sel_mux4` = 11, `sel_mux3` = 01, `en_b` = 1. If counter == NITER go to REM; else go to NK with counter + 1.
- REM: `sel_mux4` = 10, `sel_mux3` = 10, `en_rem` = 1, `en_a` = `en_b` = 0. Next state DONE.
- DONE: `done` = 1, enables 0, selects 00. Next state IDLE.
- `iter` equals the counter in N1/D1/NK/DK.
- `en_a`, `en_b` and `en_rem` are mutually exclusive in every state.
- `start` outside IDLE is ignored; there is no queueing.
- `abort` = 1 in any non-IDLE state -> IDLE at the next edge; `done` is not asserted. `abort` takes priority over every other transition, including DONE -> IDLE. `abort` in IDLE has no effect, even with `start` also high, so `start` is accepted.
- The counter is 4 bits and never wraps, because it is bounded by NITER <= 15.

## Timing
- Reset (asynchronous assert): state IDLE, counter 0, `rm` = 0, every output 0.
- Reset deassertion is synchronized by the integrating design; the block itself applies no synchronizer.
- Reset mid-operation: immediate return to IDLE with outputs 0; no `done`.
- `start` sampled at edge t -> N1 outputs valid from t through t+1.
- Enable high for one full cycle = one register load at the following edge.
- Latency from the `start` edge to the `done` cycle is 2·NITER + 2 cycles: 2·NITER iteration cycles, 1 REM cycle, then DONE.
- With NITER = 6: N1 at t+1, D1 at t+2, NK/DK from t+3 to t+12, REM at t+13, `done` at t+14, IDLE at t+15.
- Minimum spacing between accepted starts is 2·NITER + 3 cycles. A `start` held high continuously re-triggers in the first IDLE cycle after DONE.

## Test plan
- Reset, then a single `start` with `rm_in` = 1 and NITER = 6 -> checked sequence:
  - `sel_mux4`: 00, 01, (10, 11)×5, then 10 in REM.
  - `sel_mux3`: 00, 00, then 01×10, then 10 in REM.
  - `iter`: 1, 1, 2, 2, …, 6, 6.
  - `en_rem` high only at t+13; `done` only at t+14; `rm` = 1 throughout.
- `start` re-pulsed at t+5 -> ignored; sequence and `done` timing unchanged.
- `abort` asserted during DK with `iter` = 3 -> IDLE next cycle, all enables 0, no `done` pulse; a new `start` then runs a full sequence.
- Asynchronous `reset` pulsed between edges during NK -> outputs go to 0 immediately, without waiting for a clock edge; `busy` = 0.
- NITER = 2 -> the check covers the complete sequence:
  - States: N1, D1, NK, DK, REM, DONE.
  - `done` at t+6; `iter` reads 1, 1, 2, 2.
- Mutual exclusion: over 1000 random `start`/`abort` cycles, at most one of `en_a`/`en_b`/`en_rem` is high in any cycle, and `done` always comes exactly 2·NITER + 2 cycles after the `start` edge of an unaborted run.
